// File: rtl/partition_exchange_seq.sv
// ============================================================================
// Module   : partition_exchange_seq
// Purpose  : Time-step sequencer that gathers partition boundary slices,
//            strobes the exchange register, then launches the next step.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module partition_exchange_seq #(
    parameter int N_PART  = 4,
    parameter int SLICE_W = 16,
    parameter int TIMEOUT = 1023,
    parameter int STEP_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      stop,
    input  logic [STEP_W-1:0]         step_limit,
    input  logic [N_PART-1:0]         part_done,
    input  logic [N_PART*SLICE_W-1:0] part_data,
    output logic                      step_start,
    output logic                      control_valuation_sig,
    output logic [N_PART*SLICE_W-1:0] cin,
    output logic [STEP_W-1:0]         step_cnt,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_WAIT   = 3'd2,
        S_COMMIT = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    state_t                    r_state;
    logic [N_PART-1:0]         r_done_mask;
    logic [TMR_W-1:0]          r_timer;
    logic                      r_stop_pend;
    logic                      r_step_start;
    logic                      r_strobe;
    logic                      r_busy;
    logic                      r_timeout_err;
    logic [N_PART*SLICE_W-1:0] r_cin;
    logic [STEP_W-1:0]         r_step_cnt;

    logic [N_PART-1:0]         w_accept;
    logic                      w_all_done;
    logic [STEP_W-1:0]         w_cnt_inc;
    logic                      w_run_end;

    // Only first done of each partition per step is accepted; same-cycle dones count toward completion.
    assign w_accept   = part_done & ~r_done_mask;
    assign w_all_done = &(r_done_mask | part_done);
    assign w_cnt_inc  = r_step_cnt + 1'b1;
    assign w_run_end  = r_stop_pend || stop ||
                        ((step_limit != '0) && (w_cnt_inc == step_limit));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_done_mask   <= '0;
            r_timer       <= '0;
            r_stop_pend   <= 1'b0;
            r_step_start  <= 1'b0;
            r_strobe      <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_cin         <= '0;
            r_step_cnt    <= '0;
        end else begin
            r_step_start <= 1'b0;
            r_strobe     <= 1'b0;
            if (r_busy && stop) begin
                r_stop_pend <= 1'b1;
            end
            case (r_state)
                S_IDLE, S_ERR: begin
                    if (start) begin
                        r_state       <= S_START;
                        r_step_start  <= 1'b1;
                        r_busy        <= 1'b1;
                        r_step_cnt    <= '0;
                        r_stop_pend   <= 1'b0;
                        r_timeout_err <= 1'b0;
                    end
                end
                S_START: begin
                    r_done_mask <= '0;
                    r_timer     <= '0;
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    for (int i = 0; i < N_PART; i++) begin
                        if (w_accept[i]) begin
                            r_cin[i*SLICE_W +: SLICE_W] <= part_data[i*SLICE_W +: SLICE_W];
                        end
                    end
                    r_done_mask <= r_done_mask | part_done;
                    if (w_all_done) begin
                        r_state  <= S_COMMIT;
                        r_strobe <= 1'b1;
                    end else if (r_timer == TMR_LAST) begin
                        r_state       <= S_ERR;
                        r_timeout_err <= 1'b1;
                        r_busy        <= 1'b0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_COMMIT: begin
                    r_step_cnt <= w_cnt_inc;
                    if (w_run_end) begin
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                        r_stop_pend <= 1'b0;
                    end else begin
                        r_state      <= S_START;
                        r_step_start <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign step_start            = r_step_start;
    assign control_valuation_sig = r_strobe;
    assign cin                   = r_cin;
    assign step_cnt              = r_step_cnt;
    assign busy                  = r_busy;
    assign timeout_err           = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_partition_exchange_seq.sv
// ============================================================================
// Module   : tb_partition_exchange_seq
// Purpose  : Scoreboard bench for the partition exchange sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_partition_exchange_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [31:0] step_limit;
    logic [3:0]  part_done;
    logic [63:0] part_data;
    logic        step_start;
    logic        control_valuation_sig;
    logic [63:0] cin;
    logic [31:0] step_cnt;
    logic        busy;
    logic        timeout_err;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          strobe_cnt = 0;
    logic [63:0] exp_cin = '0;
    logic [3:0]  tb_mask = '0;
    logic [63:0] exp_q[$];

    partition_exchange_seq #(
        .N_PART(4), .SLICE_W(16), .TIMEOUT(1023), .STEP_W(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .step_limit(step_limit), .part_done(part_done), .part_data(part_data),
        .step_start(step_start), .control_valuation_sig(control_valuation_sig),
        .cin(cin), .step_cnt(step_cnt), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Every strobe must match the next expected exchange word.
    always @(negedge clk) begin
        if (rst_n && control_valuation_sig) begin
            strobe_cnt++;
            if (exp_q.size() == 0) chk("unexpected_strobe", 64'd1, 64'd0);
            else                   chk("cin_at_strobe", cin, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic wait_step_start(input string tag);
        int n = 0;
        do begin @(negedge clk); n++; end while (!step_start && n < 50);
        chk(tag, {63'd0, step_start}, 64'd1);
        tb_mask = '0;
        tick();
    endtask

    task automatic drive_done(input logic [3:0] m, input logic [63:0] d);
        logic was_full;
        was_full  = &tb_mask;
        part_done = m;
        part_data = d;
        for (int i = 0; i < 4; i++) begin
            if (m[i] && !tb_mask[i]) begin
                tb_mask[i] = 1'b1;
                exp_cin[i*16 +: 16] = d[i*16 +: 16];
            end
        end
        if (!was_full && (&tb_mask)) exp_q.push_back(exp_cin);
        tick();
        part_done = '0;
    endtask

    initial begin
        int s0;
        int n;
        logic seen;
        logic [3:0] m;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; step_limit = '0;
        part_done = '0; part_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_step_start", {63'd0, step_start}, 64'd0);
        chk("rst_strobe", {63'd0, control_valuation_sig}, 64'd0);
        chk("rst_cin", cin, 64'd0);
        chk("rst_step_cnt", {32'd0, step_cnt}, 64'd0);
        chk("rst_timeout", {63'd0, timeout_err}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Three steps, all dones together
        step_limit = 32'd3;
        s0 = strobe_cnt;
        pulse_start();
        for (int k = 0; k < 3; k++) begin
            wait_step_start("t1_step_start");
            drive_done(4'b1111, 64'h4444_3333_2222_1111);
        end
        repeat (4) @(negedge clk);
        chk("t1_strobes", 64'(strobe_cnt - s0), 64'd3);
        chk("t1_cin", cin, 64'h4444_3333_2222_1111);
        chk("t1_step_cnt", {32'd0, step_cnt}, 64'd3);
        chk("t1_busy", {63'd0, busy}, 64'd0);
        tick();

        // Staggered dones, then latency of strobe and next step_start
        step_limit = 32'd2;
        pulse_start();
        wait_step_start("t2_step_start");
        s0 = strobe_cnt;
        for (int c = 0; c < 10; c++) begin
            m = (c == 2) ? 4'b0001 : (c == 5) ? 4'b1000 :
                (c == 7) ? 4'b0010 : (c == 9) ? 4'b0100 : 4'b0000;
            if (m != 4'b0000)
                drive_done(m, {16'h3A00 + 16'(c), 16'h2B00 + 16'(c), 16'h1C00 + 16'(c), 16'h0D00 + 16'(c)});
            else
                tick();
        end
        chk("t2_no_early_strobe", 64'(strobe_cnt - s0), 64'd0);
        @(negedge clk);
        chk("t2_strobe_lat", {63'd0, control_valuation_sig}, 64'd1);
        @(negedge clk);
        chk("t2_step_start_lat", {63'd0, step_start}, 64'd1);
        tb_mask = '0;
        tick();

        // Duplicate done must not overwrite the first slice
        drive_done(4'b0001, 64'h0000_0000_0000_AAA0);
        drive_done(4'b0010, 64'h0000_0000_5555_0000);
        drive_done(4'b0010, 64'h0000_0000_BEEF_0000);
        drive_done(4'b0100, 64'h0000_7777_0000_0000);
        drive_done(4'b1000, 64'h9999_0000_0000_0000);
        repeat (4) @(negedge clk);
        chk("t3_slice1", {48'd0, cin[31:16]}, 64'h5555);
        chk("t3_cin", cin, 64'h9999_7777_5555_AAA0);
        chk("t3_step_cnt", {32'd0, step_cnt}, 64'd2);
        chk("t3_busy", {63'd0, busy}, 64'd0);
        tick();

        // Partition 2 never reports: timeout
        step_limit = 32'd0;
        pulse_start();
        wait_step_start("t4_step_start");
        s0 = strobe_cnt;
        drive_done(4'b1011, 64'h0004_0003_0002_0001);
        n = 0;
        while (!timeout_err && n < 1200) begin @(negedge clk); n++; end
        chk("t4_timeout_flag", {63'd0, timeout_err}, 64'd1);
        chk("t4_timeout_len", {63'd0, (n >= 1000 && n <= 1030)}, 64'd1);
        chk("t4_busy", {63'd0, busy}, 64'd0);
        chk("t4_no_strobe", 64'(strobe_cnt - s0), 64'd0);
        tick();
        pulse_start();
        wait_step_start("t4_resume");
        chk("t4_flag_clear", {63'd0, timeout_err}, 64'd0);
        chk("t4_cnt_clear", {32'd0, step_cnt}, 64'd0);

        // Stop mid-WAIT: current step still commits, then idle
        s0 = strobe_cnt;
        drive_done(4'b0001, 64'h0000_0000_0000_C001);
        stop = 1'b1; tick(); stop = 1'b0;
        tick();
        drive_done(4'b1110, 64'hC004_C003_C002_0000);
        @(negedge clk);
        chk("t5_strobe", {63'd0, control_valuation_sig}, 64'd1);
        @(negedge clk);
        chk("t5_no_restart", {63'd0, step_start}, 64'd0);
        chk("t5_busy", {63'd0, busy}, 64'd0);
        chk("t5_step_cnt", {32'd0, step_cnt}, 64'd1);
        chk("t5_strobes", 64'(strobe_cnt - s0), 64'd1);
        tick();

        // Asynchronous reset in WAIT with three of four dones
        pulse_start();
        wait_step_start("t6_step_start");
        drive_done(4'b0111, 64'h0000_6663_6662_6661);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("t6_busy", {63'd0, busy}, 64'd0);
        chk("t6_cin", cin, 64'd0);
        chk("t6_step_cnt", {32'd0, step_cnt}, 64'd0);
        chk("t6_timeout", {63'd0, timeout_err}, 64'd0);
        chk("t6_step_start", {63'd0, step_start}, 64'd0);
        chk("t6_strobe", {63'd0, control_valuation_sig}, 64'd0);
        exp_q.delete();
        exp_cin = '0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (busy || step_start || control_valuation_sig) seen = 1'b1;
        end
        chk("t6_stays_idle", {63'd0, seen}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
